// File: rtl/input_pkg.sv
// Shared definitions for the jump-key injection path: opcode/register constants,
// injector FSM state type and the addi word builder.
package input_pkg;

  localparam logic [4:0] OPC_ADDI = 5'd5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } inj_state_t;

  // addi rd, $0, 1
  function automatic logic [31:0] build_addi(input logic [4:0] rd);
    return {OPC_ADDI, rd, REG_ZERO, 17'd1};
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and
// rising-edge pulse on the debounced level.
module key_debouncer
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_raw,
  output logic db,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync_q1;
  logic            key_sync;
  logic            db_q;
  logic [CntW-1:0] cnt;

  // Two-stage synchroniser for the asynchronous button level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1  <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      sync_q1  <= key_raw;
      key_sync <= sync_q1;
    end
  end

  // Count consecutive differing cycles; any agreement restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (key_sync == db) begin
      cnt <= '0;
    end else if (cnt == CntMax) begin
      cnt <= '0;
      db  <= ~db;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // One-cycle delayed copy of the debounced level for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_q <= 1'b0;
    end else begin
      db_q <= db;
    end
  end

  // Only press edges matter; release edges are ignored.
  assign press = db & ~db_q;

endmodule

// File: rtl/jump_key_injector.sv
// Injects one "addi $FLAG_REG, $0, 1" into the decode stream per debounced
// jump-button press, holding a single pending request and counting presses
// that arrive while one is already outstanding.
module jump_key_injector
  import input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned FLAG_REG        = 29
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        key_raw,
  input  logic [31:0] fetch_insn_in,
  input  logic        slot_ready,
  output logic [31:0] insn_out,
  output logic        inject_valid,
  output logic        pc_hold,
  output logic [7:0]  coalesced
);

  localparam logic [31:0] InjWord = build_addi(5'(FLAG_REG));

  logic       db;
  logic       press;
  inj_state_t state_q, state_d;
  logic [7:0] coal_q, coal_d;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock  (clock),
    .reset_n(reset_n),
    .key_raw(key_raw),
    .db     (db),
    .press  (press)
  );

  // Next-state and coalesce-counter logic for the single-entry request slot.
  always_comb begin
    state_d = state_q;
    coal_d  = coal_q;
    case (state_q)
      IDLE: begin
        if (press) state_d = PENDING;
      end
      PENDING: begin
        // Accept with a simultaneous press re-arms as a fresh request.
        if (slot_ready && !press) begin
          state_d = IDLE;
        end else if (!slot_ready && press && (coal_q != 8'hFF)) begin
          coal_d = coal_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and coalesce counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      coal_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      coal_q  <= coal_d;
    end
  end

  assign inject_valid = (state_q == PENDING);
  assign pc_hold      = inject_valid & slot_ready;
  assign insn_out     = inject_valid ? InjWord : fetch_insn_in;
  assign coalesced    = coal_q;

endmodule
